hms_clock_ctrl: RTL and testbench

Real-time-of-day keeper with a button-driven set mode. Produces hour/minute/second binary fields and a 6-bit edit-highlight mask. The fields are split by the double-figure separator and decoded by the FND decoders. The mask drives the per-digit decimal points of the six-digit multiplexed display. It sits directly upstream of the display path and replaces the free-running 0–59 counter as the source of displayed numbers.

---
 rtl/hms_pkg.sv | 20 ++
 rtl/sw_edge.sv | 53 +++++
 rtl/hms_clock_ctrl.sv | 75 +++++++
 tb/tb_hms_clock_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hms_pkg.sv
// hms_pkg: shared mode codes, field limits and helpers for the time-of-day keeper
package hms_pkg;
    localparam logic [1:0] MODE_CLOCK    = 2'd0;
    localparam logic [1:0] MODE_SET_SEC  = 2'd1;
    localparam logic [1:0] MODE_SET_MIN  = 2'd2;
    localparam logic [1:0] MODE_SET_HOUR = 2'd3;
    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;

    function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] lim);
        return (v == lim) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] dp_mask(input logic [1:0] mode);
        return (mode == MODE_SET_SEC)  ? 6'b000011 :
               (mode == MODE_SET_MIN)  ? 6'b001100 :
               (mode == MODE_SET_HOUR) ? 6'b110000 : 6'b000000;
    endfunction
endpackage

// File: rtl/sw_edge.sv
// sw_edge: 2-FF synchronizer, optional debouncer (HMS_CLOCK_CTRL_DEBOUNCE_EN), rising-edge pulse
module sw_edge #(
    parameter int DEB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sw,
    output logic o_pulse
);
    logic s1_q, s2_q, lvl_q, pulse_q, stable;
`ifdef HMS_CLOCK_CTRL_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES + 1);
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          deb_q, deb_d;
    // accept a new level only after DEB_CYCLES consecutive differing samples
    always_comb begin
        deb_d  = deb_q;
        dcnt_d = '0;
        if (s2_q != deb_q) begin
            if (dcnt_q == DW'(DEB_CYCLES - 1)) deb_d = s2_q;
            else dcnt_d = dcnt_q + 1'b1;
        end
    end
    // debounce state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q <= '0;
            deb_q  <= 1'b0;
        end else begin
            dcnt_q <= dcnt_d;
            deb_q  <= deb_d;
        end
    end
    assign stable = deb_q;
`else
    assign stable = s2_q;
`endif
    // synchronize, then register a one-cycle pulse on each accepted rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            lvl_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= i_sw;
            s2_q    <= s1_q;
            lvl_q   <= stable;
            pulse_q <= stable & ~lvl_q;
        end
    end
    assign o_pulse = pulse_q;
endmodule

// File: rtl/hms_clock_ctrl.sv
// hms_clock_ctrl: time-of-day keeper with button set mode; debounce via HMS_CLOCK_CTRL_DEBOUNCE_EN
module hms_clock_ctrl
    import hms_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int DEB_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sw_mode,
    input  logic       i_sw_inc,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic [1:0] o_mode,
    output logic [5:0] o_six_dp
);
    localparam int CW = $clog2(CLK_HZ);
    logic          mode_p, inc_p, tick, edit;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    mode_q, mode_d;
    logic [5:0]    sec_q, sec_d, min_q, min_d, dp_q, dp_d;
    logic [4:0]    hour_q, hour_d;

    sw_edge #(.DEB_CYCLES(DEB_CYCLES)) u_sw_mode (.clk(clk), .rst_n(rst_n), .i_sw(i_sw_mode), .o_pulse(mode_p));
    sw_edge #(.DEB_CYCLES(DEB_CYCLES)) u_sw_inc  (.clk(clk), .rst_n(rst_n), .i_sw(i_sw_inc),  .o_pulse(inc_p));

    // next-state: tick counter, mode advance, field carry chain or edit, dp mask
    always_comb begin
        tick   = (mode_q == MODE_CLOCK) && (cnt_q == CW'(CLK_HZ - 1));
        cnt_d  = (mode_q != MODE_CLOCK || tick) ? '0 : cnt_q + 1'b1;
        mode_d = mode_p ? mode_q + 2'd1 : mode_q;
        edit   = inc_p && !mode_p;
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        if (tick) begin
            sec_d = inc_wrap(sec_q, SEC_MAX);
            if (sec_q == SEC_MAX) begin
                min_d = inc_wrap(min_q, MIN_MAX);
                if (min_q == MIN_MAX) hour_d = 5'(inc_wrap({1'b0, hour_q}, {1'b0, HOUR_MAX}));
            end
        end else if (edit) begin
            if (mode_q == MODE_SET_SEC)  sec_d  = inc_wrap(sec_q, SEC_MAX);
            if (mode_q == MODE_SET_MIN)  min_d  = inc_wrap(min_q, MIN_MAX);
            if (mode_q == MODE_SET_HOUR) hour_d = 5'(inc_wrap({1'b0, hour_q}, {1'b0, HOUR_MAX}));
        end
        dp_d = dp_mask(mode_d);
    end

    // state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            mode_q <= MODE_CLOCK;
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
            dp_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
            dp_q   <= dp_d;
        end
    end

    assign o_sec    = sec_q;
    assign o_min    = min_q;
    assign o_hour   = hour_q;
    assign o_mode   = mode_q;
    assign o_six_dp = dp_q;
endmodule

// File: tb/tb_hms_clock_ctrl.sv
// tb_hms_clock_ctrl: self-checking bench with a seconds-of-day reference model
module tb_hms_clock_ctrl;
    localparam int HZ  = 10;
    localparam int DEB = 4;

    logic       clk = 1'b0, rst_n = 1'b0, sw_mode = 1'b0, sw_inc = 1'b0;
    logic [5:0] o_sec, o_min, o_six_dp;
    logic [4:0] o_hour;
    logic [1:0] o_mode;

    int checks = 0, errors = 0;
    int t = 0, mmode = 0, ph = 0;
    bit hm[4], hi[4];

    typedef struct {
        int presses;
        int exp_mode;
        int exp_dp;
    } vec_t;
    vec_t tbl[5];

    hms_clock_ctrl #(.CLK_HZ(HZ), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .i_sw_mode(sw_mode), .i_sw_inc(sw_inc),
        .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour), .o_mode(o_mode), .o_six_dp(o_six_dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_dp(input int m);
        return (m == 0) ? 0 : (3 << (2 * (m - 1)));
    endfunction

    task automatic bump(input int m);
        int s, mi, h;
        s = t % 60; mi = (t / 60) % 60; h = t / 3600;
        if (m == 1) s = (s + 1) % 60;
        if (m == 2) mi = (mi + 1) % 60;
        if (m == 3) h = (h + 1) % 24;
        t = h * 3600 + mi * 60 + s;
    endtask

    // one clock: advance the model at the posedge, compare at the following negedge
    task automatic step();
        bit pm, pi;
        @(posedge clk);
        if (!rst_n) begin
            t = 0; mmode = 0; ph = 0;
            for (int k = 0; k < 4; k++) begin hm[k] = 0; hi[k] = 0; end
        end else begin
            pm = hm[2] && !hm[3];
            pi = hi[2] && !hi[3];
            if (mmode == 0) begin
                if (ph == HZ - 1) begin ph = 0; t = (t + 1) % 86400; end
                else ph++;
            end else ph = 0;
            if (pm) mmode = (mmode + 1) % 4;
            else if (pi && mmode != 0) bump(mmode);
            for (int k = 3; k > 0; k--) begin hm[k] = hm[k-1]; hi[k] = hi[k-1]; end
            hm[0] = sw_mode; hi[0] = sw_inc;
        end
        @(negedge clk);
`ifndef HMS_CLOCK_CTRL_DEBOUNCE_EN
        chk("model_sec",  int'(o_sec),    t % 60);
        chk("model_min",  int'(o_min),    (t / 60) % 60);
        chk("model_hour", int'(o_hour),   t / 3600);
        chk("model_mode", int'(o_mode),   mmode);
        chk("model_dp",   int'(o_six_dp), model_dp(mmode));
`endif
    endtask

    task automatic press(input bit m, input bit i, input int hold, input int gap);
        sw_mode = m; sw_inc = i;
        repeat (hold) step();
        sw_mode = 0; sw_inc = 0;
        repeat (gap) step();
    endtask

    task automatic do_reset();
        rst_n = 0; sw_mode = 0; sw_inc = 0;
        #1;
        chk("rst_async_sec", int'(o_sec), 0);
        step(); step();
        chk("rst_all", int'({o_sec, o_min, o_hour, o_mode, o_six_dp}), 0);
        rst_n = 1;
    endtask

    initial begin
        tbl[0] = '{0, 0, 6'b000000};
        tbl[1] = '{1, 1, 6'b000011};
        tbl[2] = '{2, 2, 6'b001100};
        tbl[3] = '{3, 3, 6'b110000};
        tbl[4] = '{4, 0, 6'b000000};
        @(negedge clk);
        do_reset();
`ifndef HMS_CLOCK_CTRL_DEBOUNCE_EN
        repeat (599) step();
        chk("run599_sec", int'(o_sec), 59);
        step();
        chk("run600_min", int'(o_min), 1);
        chk("run600_sec", int'(o_sec), 0);

        do_reset();
        press(1, 0, 1, 3);
        repeat (59) press(0, 1, 1, 3);
        press(1, 0, 1, 3);
        repeat (59) press(0, 1, 1, 3);
        press(1, 0, 1, 3);
        repeat (23) press(0, 1, 1, 3);
        press(1, 0, 1, 3);
        chk("preload_hms", int'({o_hour, o_min, o_sec}), int'({5'd23, 6'd59, 6'd59}));
        repeat (9) step();
        chk("preload_still", int'(o_sec), 59);
        step();
        chk("rollover", int'({o_hour, o_min, o_sec}), 0);

        press(1, 0, 1, 3);
        chk("setsec_mode", int'(o_mode), 1);
        chk("setsec_dp", int'(o_six_dp), 6'b000011);
        repeat (100) step();
        chk("setsec_frozen", int'(o_sec), 0);
        repeat (61) press(0, 1, 1, 3);
        chk("inc61_sec", int'(o_sec), 1);
        chk("inc61_min", int'(o_min), 0);

        press(1, 0, 1, 3);
        press(1, 0, 1, 3);
        repeat (23) press(0, 1, 1, 3);
        chk("hour23", int'(o_hour), 23);
        press(0, 1, 1, 3);
        chk("hour_wrap", int'(o_hour), 0);
        press(1, 0, 1, 3);
        chk("back_mode", int'(o_mode), 0);
        chk("back_dp", int'(o_six_dp), 0);
        repeat (9) step();
        chk("first_sec_wait", int'(o_sec), 1);
        step();
        chk("first_sec_tick", int'(o_sec), 2);

        press(1, 0, 1, 3);
        press(1, 0, 1, 3);
        press(1, 1, 1, 3);
        chk("simul_mode", int'(o_mode), 3);
        chk("simul_min", int'(o_min), 0);
        press(0, 1, 50, 4);
        chk("hold_one_inc", int'(o_hour), 1);

        foreach (tbl[n]) begin
            do_reset();
            repeat (tbl[n].presses) press(1, 0, 1, 3);
            chk("tbl_mode", int'(o_mode), tbl[n].exp_mode);
            chk("tbl_dp", int'(o_six_dp), tbl[n].exp_dp);
        end

        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0) sw_mode = ~sw_mode;
            if ($urandom_range(0, 3) == 0) sw_inc = ~sw_inc;
            if ($urandom_range(0, 599) == 0) rst_n = 0;
            else rst_n = 1;
            step();
        end
`else
        press(1, 0, 8, 12);
        chk("deb_mode", int'(o_mode), 1);
        press(0, 1, 3, 12);
        chk("deb_glitch", int'(o_sec), 0);
        press(0, 1, 6, 12);
        chk("deb_press", int'(o_sec), 1);
        sw_inc = 1;
        repeat (3) step();
        rst_n = 0;
        step();
        chk("deb_rst_all", int'({o_sec, o_min, o_hour, o_mode, o_six_dp}), 0);
        rst_n = 1;
        repeat (3) step();
        sw_inc = 0;
        repeat (2) step();
        chk("deb_rst_after", int'({o_sec, o_min, o_hour, o_mode, o_six_dp}), 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
